// File: rtl/cfg_resp_arb.sv
`default_nettype none
// ============================================================================
// Module      : cfg_resp_arb
// Description : Round-robin arbiter that funnels responses from NUM_REQ config
//               responders into one shared response FIFO. Every issue is gated
//               on FIFO credits; the FIFO load interface and the requester
//               acks are registered single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_resp_arb #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_opcode,
  input  logic [4*NUM_REQ-1:0]    req_code,
  input  logic [16*NUM_REQ-1:0]   req_capptag,
  input  logic [4*NUM_REQ-1:0]    req_rdata_offset,
  input  logic [NUM_REQ-1:0]      req_rdata_bdi,
  input  logic [32*NUM_REQ-1:0]   req_rdata_bus,
  output logic [NUM_REQ-1:0]      req_ack,
  input  logic [3:0]              resp_buffers_available,
  input  logic                    fifo_overflow,
  output logic [7:0]              cfg_rff_resp_opcode,
  output logic [3:0]              cfg_rff_resp_code,
  output logic [15:0]             cfg_rff_resp_capptag,
  output logic [3:0]              cfg_rff_rdata_offset,
  output logic                    cfg_rff_rdata_bdi,
  output logic [31:0]             cfg_rff_rdata_bus,
  output logic                    cfg_rff_resp_in_valid,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [15:0]             resp_issued_cnt,
  output logic                    arb_error
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  localparam logic [4:0]       C_DEPTH   = 5'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] C_PTR_RST = IDX_W'(NUM_REQ - 1);

  state_t               state_q,   state_d;
  logic [IDX_W-1:0]     rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]     grant_q,   grant_d;
  logic [15:0]          cnt_q,     cnt_d;
  logic                 err_q,     err_d;
  logic                 valid_q,   valid_d;
  logic [NUM_REQ-1:0]   ack_q,     ack_d;
  logic [7:0]           opcode_q,  opcode_d;
  logic [3:0]           code_q,    code_d;
  logic [15:0]          capptag_q, capptag_d;
  logic [3:0]           offset_q,  offset_d;
  logic                 bdi_q,     bdi_d;
  logic [31:0]          bus_q,     bus_d;

  logic [4:0]           eff_credit;
  logic                 found;

  // A strobe in flight this cycle is not yet reflected in the credit count.
  always_comb begin
    if ({1'b0, resp_buffers_available} > {4'b0000, valid_q})
      eff_credit = {1'b0, resp_buffers_available} - {4'b0000, valid_q};
    else
      eff_credit = 5'd0;
  end

  // Next-state, round-robin winner selection and registered-output staging.
  always_comb begin
    state_d   = S_IDLE;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    ack_d     = '0;
    opcode_d  = '0;
    code_d    = '0;
    capptag_d = '0;
    offset_d  = '0;
    bdi_d     = 1'b0;
    bus_d     = '0;
    found     = 1'b0;
    err_d     = err_q | fifo_overflow |
                ({1'b0, resp_buffers_available} > C_DEPTH);

    case (state_q)
      S_IDLE: begin
        if ((|req_valid) && (eff_credit != 5'd0)) begin
          // Search upward from the slot after the last winner, wrapping.
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
              found     = 1'b1;
              rr_ptr_d  = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
              grant_d   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
              ack_d[(int'(rr_ptr_q) + k) % NUM_REQ] = 1'b1;
              opcode_d  = req_opcode[8*((int'(rr_ptr_q) + k) % NUM_REQ) +: 8];
              code_d    = req_code[4*((int'(rr_ptr_q) + k) % NUM_REQ) +: 4];
              capptag_d = req_capptag[16*((int'(rr_ptr_q) + k) % NUM_REQ) +: 16];
              offset_d  = req_rdata_offset[4*((int'(rr_ptr_q) + k) % NUM_REQ) +: 4];
              bdi_d     = req_rdata_bdi[(int'(rr_ptr_q) + k) % NUM_REQ];
              bus_d     = req_rdata_bus[32*((int'(rr_ptr_q) + k) % NUM_REQ) +: 32];
            end
          end
        end
        if (found) begin
          valid_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_ISSUE;
        end
      end
      // One-cycle bubble: lets the acked requester drop req_valid unseen.
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= C_PTR_RST;
      grant_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= '0;
      opcode_q  <= '0;
      code_q    <= '0;
      capptag_q <= '0;
      offset_q  <= '0;
      bdi_q     <= 1'b0;
      bus_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      opcode_q  <= opcode_d;
      code_q    <= code_d;
      capptag_q <= capptag_d;
      offset_q  <= offset_d;
      bdi_q     <= bdi_d;
      bus_q     <= bus_d;
    end
  end

  assign req_ack               = ack_q;
  assign cfg_rff_resp_in_valid = valid_q;
  assign cfg_rff_resp_opcode   = opcode_q;
  assign cfg_rff_resp_code     = code_q;
  assign cfg_rff_resp_capptag  = capptag_q;
  assign cfg_rff_rdata_offset  = offset_q;
  assign cfg_rff_rdata_bdi     = bdi_q;
  assign cfg_rff_rdata_bus     = bus_q;
  assign grant_idx             = grant_q;
  assign resp_issued_cnt       = cnt_q;
  assign arb_error             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_resp_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_resp_arb
// Description : Directed self-checking bench for cfg_resp_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_resp_arb;

  localparam int NUM_REQ = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [31:0]   req_opcode;
  logic [15:0]   req_code;
  logic [63:0]   req_capptag;
  logic [15:0]   req_rdata_offset;
  logic [3:0]    req_rdata_bdi;
  logic [127:0]  req_rdata_bus;
  logic [3:0]    req_ack;
  logic [3:0]    resp_buffers_available;
  logic          fifo_overflow;
  logic [7:0]    cfg_rff_resp_opcode;
  logic [3:0]    cfg_rff_resp_code;
  logic [15:0]   cfg_rff_resp_capptag;
  logic [3:0]    cfg_rff_rdata_offset;
  logic          cfg_rff_rdata_bdi;
  logic [31:0]   cfg_rff_rdata_bus;
  logic          cfg_rff_resp_in_valid;
  logic [1:0]    grant_idx;
  logic [15:0]   resp_issued_cnt;
  logic          arb_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cfg_resp_arb #(.NUM_REQ(4), .IDX_W(2), .FIFO_DEPTH(8)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_opcode             (req_opcode),
    .req_code               (req_code),
    .req_capptag            (req_capptag),
    .req_rdata_offset       (req_rdata_offset),
    .req_rdata_bdi          (req_rdata_bdi),
    .req_rdata_bus          (req_rdata_bus),
    .req_ack                (req_ack),
    .resp_buffers_available (resp_buffers_available),
    .fifo_overflow          (fifo_overflow),
    .cfg_rff_resp_opcode    (cfg_rff_resp_opcode),
    .cfg_rff_resp_code      (cfg_rff_resp_code),
    .cfg_rff_resp_capptag   (cfg_rff_resp_capptag),
    .cfg_rff_rdata_offset   (cfg_rff_rdata_offset),
    .cfg_rff_rdata_bdi      (cfg_rff_rdata_bdi),
    .cfg_rff_rdata_bus      (cfg_rff_rdata_bus),
    .cfg_rff_resp_in_valid  (cfg_rff_resp_in_valid),
    .grant_idx              (grant_idx),
    .resp_issued_cnt        (resp_issued_cnt),
    .arb_error              (arb_error)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '0;
    fifo_overflow = 1'b0;
    resp_buffers_available = 4'd8;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (cfg_rff_resp_in_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", cfg_rff_resp_in_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", req_ack);
    else pass_cnt++;
    total_cnt++;
    if (resp_issued_cnt !== 16'h0000) $display("FAIL reset_cnt got %h exp 0000", resp_issued_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({grant_idx, arb_error, cfg_rff_resp_opcode, cfg_rff_resp_capptag} !== 27'd0)
      $display("FAIL reset_misc got grant=%0d err=%0b op=%h tag=%h exp all 0",
               grant_idx, arb_error, cfg_rff_resp_opcode, cfg_rff_resp_capptag);
    else pass_cnt++;
  endtask

  task automatic test_single();
    req_opcode[15:8]   = 8'h01;
    req_capptag[31:16] = 16'hBEEF;
    req_rdata_bus[63:32] = 32'hCAFE_0001;
    req_valid = 4'b0010;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, cfg_rff_resp_opcode, cfg_rff_resp_capptag} !== {1'b1, 8'h01, 16'hBEEF})
      $display("FAIL single_payload got v=%0b op=%h tag=%h exp v=1 op=01 tag=BEEF",
               cfg_rff_resp_in_valid, cfg_rff_resp_opcode, cfg_rff_resp_capptag);
    else pass_cnt++;
    total_cnt++;
    if ({req_ack, grant_idx, resp_issued_cnt} !== {4'b0010, 2'd1, 16'd1})
      $display("FAIL single_ack got ack=%b grant=%0d cnt=%0d exp ack=0010 grant=1 cnt=1",
               req_ack, grant_idx, resp_issued_cnt);
    else pass_cnt++;
    total_cnt++;
    if (cfg_rff_rdata_bus !== 32'hCAFE_0001) $display("FAIL single_bus got %h exp CAFE0001", cfg_rff_rdata_bus);
    else pass_cnt++;
    req_valid = 4'b0000;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack, cfg_rff_resp_opcode, cfg_rff_resp_capptag, cfg_rff_rdata_bus} !== 61'd0)
      $display("FAIL single_idle got v=%0b ack=%b op=%h tag=%h bus=%h exp all 0",
               cfg_rff_resp_in_valid, req_ack, cfg_rff_resp_opcode, cfg_rff_resp_capptag, cfg_rff_rdata_bus);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] pend;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_opcode[8*i +: 8] = 8'h10 + 8'(i);
    pend = 4'b1111;
    req_valid = pend;
    for (int i = 0; i < NUM_REQ; i++) begin
      @(negedge clock);
      total_cnt++;
      if ({cfg_rff_resp_in_valid, grant_idx, req_ack, cfg_rff_resp_opcode} !==
          {1'b1, 2'(i), 4'(1 << i), 8'h10 + 8'(i)})
        $display("FAIL rr_grant%0d got v=%0b grant=%0d ack=%b op=%h exp v=1 grant=%0d op=%h",
                 i, cfg_rff_resp_in_valid, grant_idx, req_ack, cfg_rff_resp_opcode, i, 8'h10 + 8'(i));
      else pass_cnt++;
      pend[i] = 1'b0;
      req_valid = pend;
      @(negedge clock);
      total_cnt++;
      if ({cfg_rff_resp_in_valid, req_ack} !== 5'd0)
        $display("FAIL rr_bubble%0d got v=%0b ack=%b exp 0", i, cfg_rff_resp_in_valid, req_ack);
      else pass_cnt++;
    end
    total_cnt++;
    if (resp_issued_cnt !== 16'd4) $display("FAIL rr_cnt got %0d exp 4", resp_issued_cnt);
    else pass_cnt++;
  endtask

  task automatic test_credit_stall();
    int bad;
    do_reset();
    resp_buffers_available = 4'd0;
    req_valid = 4'b0001;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (cfg_rff_resp_in_valid !== 1'b0 || req_ack !== 4'b0000) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL credit_stall got %0d issuing cycles exp 0", bad);
    else pass_cnt++;
    resp_buffers_available = 4'd1;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack} !== {1'b1, 4'b0001})
      $display("FAIL credit_release got v=%0b ack=%b exp v=1 ack=0001", cfg_rff_resp_in_valid, req_ack);
    else pass_cnt++;
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_credit_accounting();
    do_reset();
    resp_buffers_available = 4'd1;
    req_valid = 4'b0011;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack} !== {1'b1, 4'b0001})
      $display("FAIL acct_first got v=%0b ack=%b exp v=1 ack=0001", cfg_rff_resp_in_valid, req_ack);
    else pass_cnt++;
    req_valid = 4'b0010;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack} !== 5'd0)
      $display("FAIL acct_hold got v=%0b ack=%b exp 0", cfg_rff_resp_in_valid, req_ack);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack, grant_idx} !== {1'b1, 4'b0010, 2'd1})
      $display("FAIL acct_second got v=%0b ack=%b grant=%0d exp v=1 ack=0010 grant=1",
               cfg_rff_resp_in_valid, req_ack, grant_idx);
    else pass_cnt++;
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_withdraw();
    do_reset();
    resp_buffers_available = 4'd0;
    req_valid = 4'b0100;
    @(negedge clock);
    @(negedge clock);
    req_valid = 4'b0000;
    resp_buffers_available = 4'd8;
    @(negedge clock);
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack, arb_error, resp_issued_cnt} !== 22'd0)
      $display("FAIL withdraw got v=%0b ack=%b err=%0b cnt=%0d exp all 0",
               cfg_rff_resp_in_valid, req_ack, arb_error, resp_issued_cnt);
    else pass_cnt++;
  endtask

  task automatic test_errors_reset();
    do_reset();
    fifo_overflow = 1'b1;
    @(negedge clock);
    fifo_overflow = 1'b0;
    total_cnt++;
    if (arb_error !== 1'b1) $display("FAIL err_overflow got %0b exp 1", arb_error);
    else pass_cnt++;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (arb_error !== 1'b1) $display("FAIL err_sticky got %0b exp 1", arb_error);
    else pass_cnt++;
    // Error does not stop arbitration; put the arbiter into ISSUE.
    req_valid = 4'b0100;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, grant_idx} !== {1'b1, 2'd2})
      $display("FAIL err_arb got v=%0b grant=%0d exp v=1 grant=2", cfg_rff_resp_in_valid, grant_idx);
    else pass_cnt++;
    reset = 1'b1;
    req_valid = 4'b0101;
    @(negedge clock);
    reset = 1'b0;
    total_cnt++;
    if ({cfg_rff_resp_in_valid, req_ack, arb_error, resp_issued_cnt} !== 22'd0)
      $display("FAIL reset_issue got v=%0b ack=%b err=%0b cnt=%0d exp all 0",
               cfg_rff_resp_in_valid, req_ack, arb_error, resp_issued_cnt);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({req_ack, grant_idx} !== {4'b0001, 2'd0})
      $display("FAIL reset_rr got ack=%b grant=%0d exp ack=0001 grant=0", req_ack, grant_idx);
    else pass_cnt++;
    req_valid = 4'b0000;
    @(negedge clock);
    // Over-range credit count is also an error.
    resp_buffers_available = 4'd9;
    @(negedge clock);
    resp_buffers_available = 4'd8;
    total_cnt++;
    if (arb_error !== 1'b1) $display("FAIL err_credit_range got %0b exp 1", arb_error);
    else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.cnt_q = 16'hFFFF;
    @(negedge clock);
    release dut.cnt_q;
    req_valid = 4'b0001;
    @(negedge clock);
    total_cnt++;
    if ({cfg_rff_resp_in_valid, resp_issued_cnt} !== {1'b1, 16'h0000})
      $display("FAIL cnt_wrap got v=%0b cnt=%h exp v=1 cnt=0000", cfg_rff_resp_in_valid, resp_issued_cnt);
    else pass_cnt++;
    req_valid = 4'b0000;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_opcode = '0;
    req_code = '0;
    req_capptag = '0;
    req_rdata_offset = '0;
    req_rdata_bdi = '0;
    req_rdata_bus = '0;
    resp_buffers_available = 4'd8;
    fifo_overflow = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_credit_accounting();
    test_withdraw();
    test_errors_reset();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
